register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register count; ADDR_W = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of asynchronous read ports.
REQ-004 The block SHALL have parameter ZERO_IDX, default 31, hardwired-zero register index; -1 disables.
REQ-005 The block SHALL have parameters INIT_IDX, default 21, and INIT_VAL, default 64'h1000, the one register that is non-zero after init.
REQ-006 The block SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding.
REQ-007 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 The block SHALL have ports regWR (input, 1, write enable), Rd (input, ADDR_W, write address) and dataWrite (input, DATA_W, write data).
REQ-010 The block SHALL have ports rd_addr (input, NUM_RD*ADDR_W, packed read addresses, port 0 in LSBs) and rd_data (output, NUM_RD*DATA_W, packed read data).
REQ-011 The block SHALL have port ready, output, 1, high once init is complete.
REQ-012 The block SHALL have ports dump_req (input, 1, start debug dump), dump_valid (output, 1), dump_idx (output, ADDR_W) and dump_data (output, DATA_W), plus dump_done (output, 1, one-cycle pulse).

Function
REQ-013 The block SHALL implement an FSM with states INIT, IDLE and DUMP, plus a shared ADDR_W-bit counter cnt.
REQ-014 In INIT, the block SHALL write one register per cycle at index cnt: INIT_VAL if cnt==INIT_IDX, else 0.
REQ-015 When cnt==NUM_REGS-1 in INIT, the block SHALL go to IDLE and assert ready on the next cycle, so ready rises NUM_REGS cycles after rst_n deasserts.
REQ-016 In INIT, the block SHALL ignore regWR and dump_req, and SHALL drive all rd_data to 0.
REQ-017 In IDLE or DUMP, when regWR==1 at a clk edge, the block SHALL write dataWrite to Rd, except when Rd==ZERO_IDX, where the write is discarded.
REQ-018 Reads on every port SHALL be combinational; a read of ZERO_IDX SHALL always return 0.
REQ-019 With BYPASS==1 and regWR==1, a read whose address equals Rd (and is not ZERO_IDX) SHALL return dataWrite in the same cycle.
REQ-020 With BYPASS==0, such a read SHALL return the old contents.
REQ-021 In IDLE, dump_req==1 SHALL move the FSM to DUMP with cnt=0.
REQ-022 In DUMP, the block SHALL assert dump_valid with dump_idx=cnt and dump_data equal to that register's stored contents (ZERO_IDX reads 0; no bypass), then increment cnt.
REQ-023 The dump SHALL run for exactly NUM_REGS consecutive cycles; on the last one the block SHALL pulse dump_done and return to IDLE.
REQ-024 A write to the index being dumped in the same cycle SHALL show the pre-write value on dump_data.
REQ-025 dump_req in DUMP SHALL be ignored; a dump SHALL never restart mid-run.
REQ-026 For non-power-of-two NUM_REGS, out-of-range read addresses SHALL return 0 and out-of-range writes SHALL be discarded.

Reset
REQ-027 While rst_n==0, the block SHALL hold state=INIT, cnt=0, ready=0, dump_valid=0 and dump_done=0, with dump_idx and dump_data at 0.
REQ-028 rst_n assertion at any time, including mid-INIT or mid-DUMP, SHALL abort immediately and restart INIT from cnt=0 after release.
REQ-029 Register array contents SHALL NOT be reset asynchronously; they are defined only by the INIT sweep.

Structure
REQ-030 Default widths, the FSM state encoding and the INIT_IDX/INIT_VAL defaults SHALL live in the shared package regfile_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the read port SHALL be a generate loop over NUM_RD.

Verification
REQ-032 Release rst_n, then count cycles: ready rises after 32 cycles; reading reg 21 returns 0x1000 and reg 5 returns 0.
REQ-033 Drive regWR=1, Rd=3, dataWrite=0xDEADBEEF with rd_addr port0=3: rd_data0 shows 0xDEADBEEF in the same cycle; with BYPASS=0 it shows 0, and 0xDEADBEEF the next cycle.
REQ-034 Write 0x55 to reg 31: a read of 31 returns 0 and the dump reports 0 at idx 31.
REQ-035 After writing reg k = k*0x11 for all k, pulse dump_req: 32 dump_valid beats with idx 0..31 and matching data, and dump_done on beat 31.
REQ-036 Assert rst_n=0 at dump beat 10: dump_valid drops immediately, a new 32-cycle INIT follows, then reg 3 reads 0.
REQ-037 Build with NUM_REGS=20, NUM_RD=3: all three ports read independently, and address 25 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, init defaults and FSM encoding for register_file_mp.
// Imported by the register file and its testbench.
package regfile_pkg;

  localparam int          DEF_DATA_W   = 64;
  localparam int          DEF_NUM_REGS = 32;
  localparam int          DEF_NUM_RD   = 2;
  localparam int          DEF_ZERO_IDX = 31;
  localparam int          DEF_INIT_IDX = 21;
  localparam logic [63:0] DEF_INIT_VAL = 64'h1000;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DUMP = 2'd2
  } rf_state_e;

endpackage

// File: rtl/register_file_mp.sv
// Multi-port register file: init sweep, write forwarding, debug dump.
// Ports: clk/rst_n; regWR/Rd/dataWrite write port; rd_addr/rd_data
// packed async read ports; ready; dump_req/valid/idx/data/done.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int                 DATA_W   = DEF_DATA_W,
  parameter int                 NUM_REGS = DEF_NUM_REGS,
  parameter int                 NUM_RD   = DEF_NUM_RD,
  parameter int                 ZERO_IDX = DEF_ZERO_IDX,
  parameter int                 INIT_IDX = DEF_INIT_IDX,
  parameter logic [DATA_W-1:0]  INIT_VAL = DATA_W'(DEF_INIT_VAL),
  parameter bit                 BYPASS   = 1'b1,
  localparam int                ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     regWR,
  input  logic [ADDR_W-1:0]        Rd,
  input  logic [DATA_W-1:0]        dataWrite,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready,
  input  logic                     dump_req,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_idx,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam logic [ADDR_W:0] NREG =
    (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS-1);

  // Indices outside the array disable the feature.
  localparam bit ZERO_EN =
    (ZERO_IDX >= 0) && (ZERO_IDX < NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_A =
    ZERO_EN ? ADDR_W'(ZERO_IDX) : '0;
  localparam bit INIT_EN =
    (INIT_IDX >= 0) && (INIT_IDX < NUM_REGS);
  localparam logic [ADDR_W-1:0] INIT_A =
    INIT_EN ? ADDR_W'(INIT_IDX) : '0;

  function automatic logic in_rng(
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} < NREG;
  endfunction

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return ZERO_EN && (a == ZERO_A);
  endfunction

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // No reset: contents come only from the init sweep.
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              usr_we;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  assign usr_we = regWR && (state_q != ST_INIT)
                  && in_rng(Rd) && !is_zero(Rd);

  always_comb begin
    we = usr_we;
    wa = Rd;
    wd = dataWrite;
    if (state_q == ST_INIT) begin
      we = 1'b1;
      wa = cnt_q;
      wd = (INIT_EN && cnt_q == INIT_A)
           ? INIT_VAL : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_DUMP;
          cnt_d   = '0;
        end
      end
      ST_DUMP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign ready = (state_q != ST_INIT);

  // Dump reads stored contents, never the bypass path.
  always_comb begin
    dump_valid = 1'b0;
    dump_idx   = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    if (state_q == ST_DUMP) begin
      dump_valid = 1'b1;
      dump_idx   = cnt_q;
      dump_done  = (cnt_q == LAST);
      if (!is_zero(cnt_q)) dump_data = mem_q[cnt_q];
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    assign ra = rd_addr[p*ADDR_W +: ADDR_W];
    always_comb begin
      rv = '0;
      if (state_q != ST_INIT && in_rng(ra)
          && !is_zero(ra)) begin
        if (BYPASS && usr_we && ra == Rd)
          rv = dataWrite;
        else
          rv = mem_q[ra];
      end
    end
    assign rd_data[p*DATA_W +: DATA_W] = rv;
  end

endmodule
